instr_decode_stage: RTL

- Registered instruction-decode stage for the single-cycle-to-pipelined CPU path.
- Accepts a 32-bit MIPS-style instruction plus its PC over a valid/ready handshake.
- Splits the fields, produces control signals, and sign- or zero-extends the immediate to XLEN.
- Holds the result in one pipeline register with stall and flush support, and feeds the execute stage.

---
 rtl/cpu_defs_pkg.sv | 66 ++++++
 rtl/decode_fields.sv | 135 +++++++++++++
 rtl/instr_decode_stage.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared decode definitions: opcode/funct constants, ALU op encoding, decoded bundle.
package cpu_defs_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned JIDX_W    = 26;
  localparam int unsigned ALU_OP_W  = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_LUI = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'd0,
    IMM_ZEXT = 2'd1,
    IMM_LUI  = 2'd2
  } imm_kind_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs;
    logic [REG_IDX_W-1:0] rt;
    logic [REG_IDX_W-1:0] dst_reg;
    logic [REG_IDX_W-1:0] shamt;
    logic [JIDX_W-1:0]    jtarget;
    alu_op_e              alu_op;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 branch_eq;
    logic                 branch_ne;
    logic                 jump;
    logic                 link;
    logic                 alu_src_imm;
    logic                 illegal;
  } decode_bundle_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction decoder: field split, control generation, immediate extension.
module decode_fields
  import cpu_defs_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] i_instr,
  output decode_bundle_t     o_bundle,
  output logic [XLEN-1:0]    o_imm_ext
);

  logic [5:0]           w_op;
  logic [5:0]           w_funct;
  logic [REG_IDX_W-1:0] w_rd;
  logic [15:0]          w_imm16;
  imm_kind_e            w_imm_kind;
  decode_bundle_t       w_b;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];
  assign w_rd    = i_instr[15:11];
  assign w_imm16 = i_instr[15:0];

  // Opcode/funct decode; illegal encodings have every side-effect control cleared
  always_comb begin
    w_b            = '0;
    w_imm_kind     = IMM_SEXT;
    w_b.rs         = i_instr[25:21];
    w_b.rt         = i_instr[20:16];
    w_b.shamt      = i_instr[10:6];
    w_b.jtarget    = i_instr[25:0];
    w_b.dst_reg    = i_instr[20:16];
    w_b.alu_op     = ALU_ADD;
    case (w_op)
      OP_RTYPE: begin
        w_b.dst_reg   = w_rd;
        w_b.reg_write = 1'b1;
        case (w_funct)
          FN_ADD:  w_b.alu_op = ALU_ADD;
          FN_SUB:  w_b.alu_op = ALU_SUB;
          FN_AND:  w_b.alu_op = ALU_AND;
          FN_OR:   w_b.alu_op = ALU_OR;
          FN_SLT:  w_b.alu_op = ALU_SLT;
          FN_SLL:  w_b.alu_op = ALU_SLL;
          FN_SRL:  w_b.alu_op = ALU_SRL;
          FN_JR: begin
            w_b.jump      = 1'b1;
            w_b.reg_write = 1'b0;
          end
          default: w_b.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        w_b.reg_write   = 1'b1;
        w_b.alu_src_imm = 1'b1;
      end
      OP_SLTI: begin
        w_b.alu_op      = ALU_SLT;
        w_b.reg_write   = 1'b1;
        w_b.alu_src_imm = 1'b1;
      end
      OP_ANDI: begin
        w_b.alu_op      = ALU_AND;
        w_b.reg_write   = 1'b1;
        w_b.alu_src_imm = 1'b1;
        w_imm_kind      = IMM_ZEXT;
      end
      OP_ORI: begin
        w_b.alu_op      = ALU_OR;
        w_b.reg_write   = 1'b1;
        w_b.alu_src_imm = 1'b1;
        w_imm_kind      = IMM_ZEXT;
      end
      OP_LUI: begin
        w_b.alu_op      = ALU_LUI;
        w_b.reg_write   = 1'b1;
        w_b.alu_src_imm = 1'b1;
        w_imm_kind      = IMM_LUI;
      end
      OP_LW: begin
        w_b.mem_read    = 1'b1;
        w_b.reg_write   = 1'b1;
        w_b.alu_src_imm = 1'b1;
      end
      OP_SW: begin
        w_b.mem_write   = 1'b1;
        w_b.alu_src_imm = 1'b1;
      end
      OP_BEQ: begin
        w_b.alu_op    = ALU_SUB;
        w_b.branch_eq = 1'b1;
      end
      OP_BNE: begin
        w_b.alu_op    = ALU_SUB;
        w_b.branch_ne = 1'b1;
      end
      OP_J: begin
        w_b.jump    = 1'b1;
        w_b.dst_reg = '0;
      end
      OP_JAL: begin
        w_b.jump      = 1'b1;
        w_b.link      = 1'b1;
        w_b.reg_write = 1'b1;
        w_b.dst_reg   = REG_IDX_W'(31);
      end
      default: w_b.illegal = 1'b1;
    endcase
    if (w_b.dst_reg == '0) w_b.reg_write = 1'b0;
    if (w_b.illegal) begin
      w_b.reg_write   = 1'b0;
      w_b.mem_read    = 1'b0;
      w_b.mem_write   = 1'b0;
      w_b.branch_eq   = 1'b0;
      w_b.branch_ne   = 1'b0;
      w_b.jump        = 1'b0;
      w_b.link        = 1'b0;
      w_b.alu_src_imm = 1'b0;
      w_b.alu_op      = ALU_ADD;
    end
  end

  // Immediate extension to XLEN
  always_comb begin
    o_imm_ext = XLEN'($signed(w_imm16));
    case (w_imm_kind)
      IMM_ZEXT: o_imm_ext = XLEN'(w_imm16);
      IMM_LUI:  o_imm_ext = XLEN'($signed({w_imm16, 16'h0000}));
      default:  o_imm_ext = XLEN'($signed(w_imm16));
    endcase
  end

  assign o_bundle = w_b;

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with valid/ready handshake and flush.
// Optional DECODE_SKID_EN adds a 1-entry skid buffer and a registered in_ready.
module instr_decode_stage
  import cpu_defs_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   instr,
  input  logic [XLEN-1:0]      pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [REG_IDX_W-1:0] rs,
  output logic [REG_IDX_W-1:0] rt,
  output logic [REG_IDX_W-1:0] dst_reg,
  output logic [REG_IDX_W-1:0] shamt,
  output logic [XLEN-1:0]      imm_ext,
  output logic [JIDX_W-1:0]    jtarget,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 branch_eq,
  output logic                 branch_ne,
  output logic                 jump,
  output logic                 link,
  output logic                 alu_src_imm,
  output logic                 illegal
);

  decode_bundle_t    w_dec;
  logic [XLEN-1:0]   w_imm;
  decode_bundle_t    r_bundle;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_pc;
  logic              r_valid;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .i_instr   (instr),
    .o_bundle  (w_dec),
    .o_imm_ext (w_imm)
  );

`ifdef DECODE_SKID_EN
  decode_bundle_t    r_skid_bundle;
  logic [XLEN-1:0]   r_skid_imm;
  logic [XLEN-1:0]   r_skid_pc;
  logic              r_skid_valid;
  logic              w_accept;
  logic              w_slot_free;

  assign in_ready    = !r_skid_valid;
  assign w_accept    = in_valid && !r_skid_valid;
  assign w_slot_free = !r_valid || out_ready;

  // Valid bits: skid entry drains ahead of new input; flush empties both slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_slot_free) begin
      r_valid      <= r_skid_valid || w_accept;
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
    end
  end

  // Payload: output slot takes skid entry first, otherwise the live decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bundle      <= '0;
      r_imm         <= '0;
      r_pc          <= '0;
      r_skid_bundle <= '0;
      r_skid_imm    <= '0;
      r_skid_pc     <= '0;
    end else if (!flush) begin
      if (w_slot_free && r_skid_valid) begin
        r_bundle <= r_skid_bundle;
        r_imm    <= r_skid_imm;
        r_pc     <= r_skid_pc;
      end else if (w_slot_free && w_accept) begin
        r_bundle <= w_dec;
        r_imm    <= w_imm;
        r_pc     <= pc;
      end else if (!w_slot_free && w_accept) begin
        r_skid_bundle <= w_dec;
        r_skid_imm    <= w_imm;
        r_skid_pc     <= pc;
      end
    end
  end
`else
  logic w_load;

  assign in_ready = !r_valid || out_ready;
  assign w_load   = in_valid && in_ready;

  // Valid bit: flush wins over load; drained entry clears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload captured only on an unflushed load, so stalled outputs hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bundle <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
    end else if (w_load && !flush) begin
      r_bundle <= w_dec;
      r_imm    <= w_imm;
      r_pc     <= pc;
    end
  end
`endif

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign rs          = r_bundle.rs;
  assign rt          = r_bundle.rt;
  assign dst_reg     = r_bundle.dst_reg;
  assign shamt       = r_bundle.shamt;
  assign imm_ext     = r_imm;
  assign jtarget     = r_bundle.jtarget;
  assign alu_op      = ALUOP_W'(r_bundle.alu_op);
  assign reg_write   = r_bundle.reg_write;
  assign mem_read    = r_bundle.mem_read;
  assign mem_write   = r_bundle.mem_write;
  assign branch_eq   = r_bundle.branch_eq;
  assign branch_ne   = r_bundle.branch_ne;
  assign jump        = r_bundle.jump;
  assign link        = r_bundle.link;
  assign alu_src_imm = r_bundle.alu_src_imm;
  assign illegal     = r_bundle.illegal;

endmodule
